uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver; the downstream stage of the UART transmit path.
- Consumes the serial line (idle high, 1 start bit low, PAYLOAD_BITS data LSB-first, STOP_BITS stop bits high) and presents each received word as a parallel value with a one-cycle valid strobe.
- Samples each bit at its centre using a clock-cycle counter derived from CLK_HZ/BIT_RATE.
- Flags framing errors and break conditions.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz
- BIT_RATE, 9600, serial bit rate in bits/s
- PAYLOAD_BITS, 8, data bits per frame (1..16)
- STOP_BITS, 1, stop bits per frame (1..2)

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- uart_rxd  input  1  serial line, asynchronous to clk
- uart_rx_en  input  1  receive enable; gates only the detection of a new start bit
- uart_rx_busy  output  1  high while a frame is being received (state != IDLE)
- uart_rx_valid  output  1  one-cycle strobe: uart_rx_data and the flags are updated
- uart_rx_data  output  PAYLOAD_BITS  last received word, held until the next valid
- uart_rx_frame_err  output  1  qualified by valid: at least one stop bit sampled low
- uart_rx_break  output  1  qualified by valid: all data bits and every stop bit sampled low

Behaviour:
- Reset and clocking: clk, with resetn asynchronous, active-low.
- Reset values: busy=0, valid=0, data=0, frame_err=0, break=0; synchronizer flops=1; state=IDLE; counters=0.
- Constants:
  - BAUD_TICKS = CLK_HZ/BIT_RATE (integer division).
  - HALF = BAUD_TICKS/2 (integer division).
  - The baud counter is $clog2(BAUD_TICKS)+1 bits.
  - The bit counter is $clog2(PAYLOAD_BITS)+1 bits.
- Input sync: uart_rxd passes through a 2-flop synchronizer (rxd_s). All decisions use rxd_s only.
- IDLE:
  - Stay while uart_rx_en=0 or rxd_s=1.
  - On uart_rx_en=1 and rxd_s=0 at edge E0: state<=START, baud_cnt<=HALF-1.
- START:
  - Decrement baud_cnt each cycle.
  - At baud_cnt==0, sample rxd_s. If 0: state<=RECV, baud_cnt<=BAUD_TICKS-1, bit_cnt<=0. If 1: the start was a glitch; go to IDLE with no valid and no flags.
- RECV:
  - Decrement baud_cnt each cycle.
  - At baud_cnt==0: shift rxd_s into the MSB of shift_reg, shifting right, so the first received bit lands in bit 0 after PAYLOAD_BITS shifts. Increment bit_cnt and reload baud_cnt<=BAUD_TICKS-1.
  - After the PAYLOAD_BITS-th sample: state<=STOP, bit_cnt<=0.
- STOP:
  - Decrement baud_cnt each cycle.
  - At each baud_cnt==0, sample rxd_s. Any 0 sets an internal stop-error bit.
  - If this is not the last stop bit: reload baud_cnt<=BAUD_TICKS-1 and increment bit_cnt.
  - On the last stop sample (bit_cnt==STOP_BITS-1): state<=IDLE, valid<=1, data<=shift_reg, frame_err<=stop-error (including this sample), break<=(shift_reg==0)&&(every stop sample==0).
- Return timing: the block returns to IDLE at the centre of the last stop bit, so a start bit arriving immediately after the stop bit is detected.
- Timing from E0 (stop sample k is 0-based):
  - Data bit k sampled at E0+HALF+(k+1)*BAUD_TICKS.
  - Stop sample k at E0+HALF+(PAYLOAD_BITS+1+k)*BAUD_TICKS.
  - valid is high for exactly one cycle following edge E0+HALF+(PAYLOAD_BITS+STOP_BITS)*BAUD_TICKS.
- valid: deasserts on the next cycle unconditionally; there is no back-pressure. Flags are meaningful only while valid=1 and are cleared with it.
- uart_rx_data: updated only on valid, including on frame error; otherwise it holds.
- busy: registered; high from the edge after E0 until the edge that asserts valid (or the glitch return to IDLE); low in the valid cycle.
- uart_rx_en deasserted mid-frame: the current frame completes normally. Re-checked only in IDLE.
- rxd_s held low after a break frame: IDLE sees low and starts a new frame. Break-terminated back-to-back frames are permitted.
- resetn asserted mid-frame: immediately returns to reset values. No valid is generated for the partial frame.

Test Plan:
- CLK_HZ=1000, BIT_RATE=100 (BAUD_TICKS=10, HALF=5), 8N1, send 0xA5 -> one valid pulse, data=0xA5, frame_err=0, break=0; valid at E0+95; busy high for exactly the frame duration.
- Back-to-back frames 0x00, 0xFF, 0x3C with zero idle gap -> three valid pulses, each 100 cycles apart, with correct data and no flags.
- Frame 0x55 with the stop bit driven low, line high afterwards -> valid, data=0x55, frame_err=1, break=0. Line held low 30 bit-times -> valid with data=0x00, frame_err=1, break=1; the next frame 0x81 after the line returns high is received correctly.
- Low glitch of 3 cycles on an idle line -> START aborts, no valid, busy returns to 0; a following 0x12 frame is received correctly.
- uart_rx_en=0 while a frame starts -> no reception. uart_rx_en dropped mid-frame -> the frame (0xC3) still completes with valid.
- STOP_BITS=2, send 0x7E with the second stop bit low -> frame_err=1. resetn pulsed at data bit 4 of another frame -> all outputs return to reset values, no valid, and the next clean frame is received.

Source files
------------

// File: rtl/uart_rx.sv
// Serial receiver: 2-flop input synchronizer, centre-sampling baud counter,
// parallel word output with a one-cycle valid strobe plus framing/break flags.
module uart_rx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int BIT_RATE     = 9600,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_busy,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_frame_err,
  output logic                    uart_rx_break
);

  localparam int BAUD_TICKS = CLK_HZ / BIT_RATE;
  localparam int HALF       = BAUD_TICKS / 2;
  localparam int CW         = $clog2(BAUD_TICKS) + 1;
  localparam int BW         = $clog2(PAYLOAD_BITS) + 1;

  localparam logic [CW-1:0] C_HALF_M1   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_BAUD_M1   = CW'(BAUD_TICKS - 1);
  localparam logic [BW-1:0] C_LAST_DATA = BW'(PAYLOAD_BITS - 1);
  localparam logic [BW-1:0] C_LAST_STOP = BW'(STOP_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_RECV, S_STOP} state_t;

  state_t                  r_state;
  logic                    r_sync1;
  logic                    r_rxd_s;
  logic [CW-1:0]           r_baud_cnt;
  logic [BW-1:0]           r_bit_cnt;
  logic [PAYLOAD_BITS-1:0] r_shift;
  logic                    r_stop_err;
  logic                    r_stop_low;
  logic                    r_busy;
  logic                    r_valid;
  logic [PAYLOAD_BITS-1:0] r_data;
  logic                    r_frame_err;
  logic                    r_break;

  logic                    w_tick;
  logic [PAYLOAD_BITS-1:0] w_shift_next;

  assign w_tick = (r_baud_cnt == '0);

  // New bit enters at the MSB so the first (LSB) bit ends up in bit 0.
  generate
    if (PAYLOAD_BITS > 1) begin : g_shift_wide
      assign w_shift_next = {r_rxd_s, r_shift[PAYLOAD_BITS-1:1]};
    end else begin : g_shift_one
      assign w_shift_next = r_rxd_s;
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_rxd_s <= 1'b1;
    end else begin
      r_sync1 <= uart_rxd;
      r_rxd_s <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_baud_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_stop_err  <= 1'b0;
      r_stop_low  <= 1'b1;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
    end else begin
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (uart_rx_en && !r_rxd_s) begin
            r_state    <= S_START;
            r_baud_cnt <= C_HALF_M1;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (!r_rxd_s) begin
              r_state    <= S_RECV;
              r_baud_cnt <= C_BAUD_M1;
              r_bit_cnt  <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - CW'(1);
          end
        end
        S_RECV: begin
          if (w_tick) begin
            r_shift    <= w_shift_next;
            r_baud_cnt <= C_BAUD_M1;
            if (r_bit_cnt == C_LAST_DATA) begin
              r_state    <= S_STOP;
              r_bit_cnt  <= '0;
              r_stop_err <= 1'b0;
              r_stop_low <= 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + BW'(1);
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_bit_cnt == C_LAST_STOP) begin
              // Back to IDLE at the stop-bit centre so an abutting start bit is caught.
              r_state     <= S_IDLE;
              r_busy      <= 1'b0;
              r_valid     <= 1'b1;
              r_data      <= r_shift;
              r_frame_err <= r_stop_err | ~r_rxd_s;
              r_break     <= (r_shift == '0) && r_stop_low && !r_rxd_s;
            end else begin
              r_baud_cnt <= C_BAUD_M1;
              r_bit_cnt  <= r_bit_cnt + BW'(1);
              r_stop_err <= r_stop_err | ~r_rxd_s;
              r_stop_low <= r_stop_low & ~r_rxd_s;
            end
          end else begin
            r_baud_cnt <= r_baud_cnt - CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign uart_rx_busy      = r_busy;
  assign uart_rx_valid     = r_valid;
  assign uart_rx_data      = r_data;
  assign uart_rx_frame_err = r_frame_err;
  assign uart_rx_break     = r_break;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 and an 8N2 instance driven by frame tasks, checked
// against a line-sampling model that works from the recorded serial waveform.
module tb_uart_rx;

  localparam int B    = 10;
  localparam int HALF = 5;
  localparam int P    = 8;
  localparam int HMAX = 16384;

  typedef struct packed {
    logic [0:0]  d;
    logic [31:0] cyc;
    logic [7:0]  data;
    logic        fe;
    logic        brk;
  } ev_t;

  logic       clk = 1'b0;
  logic       resetn [2];
  logic       rxd    [2];
  logic       en     [2];
  logic       busy   [2];
  logic       valid  [2];
  logic       fe     [2];
  logic       brk    [2];
  logic [7:0] data   [2];

  logic hist [2][HMAX];
  logic enh  [2][HMAX];

  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   rst_rel [2];
  int   model_n [2];
  int   busy_cnt [2];
  int   busy_rise [2];
  logic prev_busy [2];
  int   t_start;

  ev_t dut_q[$];
  ev_t got_q[$];
  ev_t exp_q[$];

  always #5 clk = ~clk;

  uart_rx #(.CLK_HZ(1000), .BIT_RATE(100), .PAYLOAD_BITS(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .resetn(resetn[0]), .uart_rxd(rxd[0]), .uart_rx_en(en[0]),
    .uart_rx_busy(busy[0]), .uart_rx_valid(valid[0]), .uart_rx_data(data[0]),
    .uart_rx_frame_err(fe[0]), .uart_rx_break(brk[0]));

  uart_rx #(.CLK_HZ(1000), .BIT_RATE(100), .PAYLOAD_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .resetn(resetn[1]), .uart_rxd(rxd[1]), .uart_rx_en(en[1]),
    .uart_rx_busy(busy[1]), .uart_rx_valid(valid[1]), .uart_rx_data(data[1]),
    .uart_rx_frame_err(fe[1]), .uart_rx_break(brk[1]));

  // Edge counter and monitor: everything is sampled 1 time unit after posedge.
  initial begin
    for (int d = 0; d < 2; d++) begin
      busy_cnt[d] = 0; busy_rise[d] = -1; prev_busy[d] = 1'b0;
    end
    forever begin
      ev_t e;
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      for (int d = 0; d < 2; d++) begin
        if (cyc < HMAX) begin
          hist[d][cyc] = rxd[d];
          enh[d][cyc]  = en[d];
        end
        if (valid[d] === 1'b1) begin
          e.d = 1'(d); e.cyc = cyc; e.data = data[d]; e.fe = fe[d]; e.brk = brk[d];
          dut_q.push_back(e);
        end
        if (busy[d] === 1'b1) begin
          busy_cnt[d]++;
          if (prev_busy[d] !== 1'b1) busy_rise[d] = cyc;
        end
        prev_busy[d] = busy[d];
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL timeout: simulation did not complete within 60000 cycles");
    $fatal(1);
  end

  function automatic int nstop(input int d);
    return d + 1;
  endfunction

  // Synchronized line value that the receiver decides on at edge n.
  function automatic logic s(input int d, input int n);
    if (n - 2 < rst_rel[d]) return 1'b1;
    return hist[d][n-2];
  endfunction

  // Reference receiver: idle scan, centre sampling by arithmetic from E0.
  task automatic model_run(input int d, input int t1);
    int         n, e0, v;
    logic [7:0] dat;
    logic       f, all_low, b;
    ev_t        e;
    exp_q.delete();
    n = model_n[d];
    while (n <= t1) begin
      if (enh[d][n] === 1'b1 && s(d, n) == 1'b0) begin
        e0 = n;
        v  = e0 + HALF + (P + nstop(d)) * B;
        if (e0 + HALF > t1) break;
        if (s(d, e0 + HALF) == 1'b1) begin
          n = e0 + HALF + 1;
          continue;
        end
        if (v > t1) break;
        for (int k = 0; k < P; k++) dat[k] = s(d, e0 + HALF + (k + 1) * B);
        f = 1'b0; all_low = 1'b1;
        for (int k = 0; k < nstop(d); k++) begin
          b = s(d, e0 + HALF + (P + 1 + k) * B);
          if (!b) f = 1'b1; else all_low = 1'b0;
        end
        e.d = 1'(d); e.cyc = v; e.data = dat; e.fe = f; e.brk = (dat == 8'h00) && all_low;
        exp_q.push_back(e);
        n = v + 1;
      end else begin
        n++;
      end
    end
    model_n[d] = n;
  endtask

  task automatic grab(input int d, input int t1);
    ev_t keep[$];
    got_q.delete();
    foreach (dut_q[i]) begin
      if (dut_q[i].d == 1'(d) && int'(dut_q[i].cyc) <= t1) got_q.push_back(dut_q[i]);
      else keep.push_back(dut_q[i]);
    end
    dut_q = keep;
  endtask

  task automatic drive(input int d, input logic val, input int n);
    repeat (n) begin
      @(negedge clk);
      rxd[d] = val;
    end
  endtask

  task automatic send_frame(input int d, input logic [7:0] dv, input logic [1:0] stopv, input int gap);
    @(negedge clk);
    t_start = cyc;
    rxd[d]  = 1'b0;
    drive(d, 1'b0, B - 1);
    for (int k = 0; k < P; k++) drive(d, dv[k], B);
    for (int k = 0; k < nstop(d); k++) drive(d, stopv[k], B);
    drive(d, 1'b1, gap);
  endtask

  task automatic test_reset;
    for (int d = 0; d < 2; d++) begin
      resetn[d] = 1'b0; rxd[d] = 1'b1; en[d] = 1'b1;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_tests++;
      if ({busy[d], valid[d], data[d], fe[d], brk[d]} !== 12'h000) begin
        n_fail++;
        $display("FAIL reset_outputs d%0d: busy=%b valid=%b data=%h fe=%b brk=%b, expected all 0",
                 d, busy[d], valid[d], data[d], fe[d], brk[d]);
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      resetn[d] = 1'b1; rst_rel[d] = cyc + 1; model_n[d] = cyc + 1;
    end
    drive(0, 1'b1, 10);
    $display("[TB] reset released at cycle %0d", rst_rel[0]);
  endtask

  task automatic test_basic;
    busy_cnt[0] = 0;
    send_frame(0, 8'hA5, 2'b11, 30);
    model_run(0, cyc); grab(0, cyc);
    n_tests++;
    if (got_q.size() !== 1 || exp_q.size() !== got_q.size()) begin
      n_fail++; $display("FAIL basic_count: got %0d events, expected 1 (model %0d)", got_q.size(), exp_q.size());
    end
    foreach (got_q[i]) begin
      $display("[TB] basic d0 cyc=%0d data=%h fe=%b brk=%b", got_q[i].cyc, got_q[i].data, got_q[i].fe, got_q[i].brk);
      n_tests++;
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL basic_model: got %h, expected %h", got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() > 0) begin
      n_tests++;
      if (int'(got_q[0].cyc) !== t_start + 3 + 95 || got_q[0].data !== 8'hA5 || got_q[0].fe !== 1'b0 || got_q[0].brk !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_value: got cyc=%0d data=%h fe=%b brk=%b, expected cyc=%0d data=a5 fe=0 brk=0",
                 got_q[0].cyc, got_q[0].data, got_q[0].fe, got_q[0].brk, t_start + 98);
      end
    end
    n_tests++;
    if (busy_cnt[0] !== 95 || busy_rise[0] !== t_start + 3) begin
      n_fail++; $display("FAIL basic_busy: got %0d cycles from %0d, expected 95 from %0d", busy_cnt[0], busy_rise[0], t_start + 3);
    end
  endtask

  task automatic test_back_to_back;
    send_frame(0, 8'h00, 2'b11, 0);
    send_frame(0, 8'hFF, 2'b11, 0);
    send_frame(0, 8'h3C, 2'b11, 30);
    model_run(0, cyc); grab(0, cyc);
    n_tests++;
    if (got_q.size() !== 3 || exp_q.size() !== 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d events, expected 3 (model %0d)", got_q.size(), exp_q.size());
    end
    foreach (got_q[i]) begin
      $display("[TB] b2b d0 cyc=%0d data=%h fe=%b brk=%b", got_q[i].cyc, got_q[i].data, got_q[i].fe, got_q[i].brk);
      n_tests++;
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL b2b_model: got %h, expected %h", got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() == 3) begin
      n_tests++;
      if (got_q[1].cyc - got_q[0].cyc !== 100 || got_q[2].cyc - got_q[1].cyc !== 100 ||
          got_q[0].data !== 8'h00 || got_q[1].data !== 8'hFF || got_q[2].data !== 8'h3C ||
          (got_q[0].fe | got_q[1].fe | got_q[2].fe | got_q[0].brk) !== 1'b0) begin
        n_fail++; $display("FAIL b2b_value: got data %h %h %h spacing %0d %0d, expected 00 ff 3c spacing 100 100",
                           got_q[0].data, got_q[1].data, got_q[2].data,
                           got_q[1].cyc - got_q[0].cyc, got_q[2].cyc - got_q[1].cyc);
      end
    end
  endtask

  task automatic test_frame_err;
    send_frame(0, 8'h55, 2'b00, 20);
    drive(0, 1'b0, 30 * B);
    drive(0, 1'b1, 150);
    send_frame(0, 8'h81, 2'b11, 30);
    model_run(0, cyc); grab(0, cyc);
    n_tests++;
    if (got_q.size() !== exp_q.size() || got_q.size() < 3) begin
      n_fail++; $display("FAIL ferr_count: got %0d events, expected %0d (at least 3)", got_q.size(), exp_q.size());
    end
    foreach (got_q[i]) begin
      $display("[TB] ferr d0 cyc=%0d data=%h fe=%b brk=%b", got_q[i].cyc, got_q[i].data, got_q[i].fe, got_q[i].brk);
      n_tests++;
      if (i < exp_q.size() && got_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL ferr_model: got %h, expected %h", got_q[i], exp_q[i]);
      end
    end
    if (got_q.size() >= 3) begin
      n_tests++;
      if ({got_q[0].data, got_q[0].fe, got_q[0].brk} !== {8'h55, 1'b1, 1'b0}) begin
        n_fail++; $display("FAIL ferr_stop_low: got data=%h fe=%b brk=%b, expected 55 1 0", got_q[0].data, got_q[0].fe, got_q[0].brk);
      end
      n_tests++;
      if ({got_q[1].data, got_q[1].fe, got_q[1].brk} !== {8'h00, 1'b1, 1'b1}) begin
        n_fail++; $display("FAIL ferr_break: got data=%h fe=%b brk=%b, expected 00 1 1", got_q[1].data, got_q[1].fe, got_q[1].brk);
      end
      n_tests++;
      if ({got_q[$].data, got_q[$].fe, got_q[$].brk} !== {8'h81, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL ferr_recover: got data=%h fe=%b brk=%b, expected 81 0 0", got_q[$].data, got_q[$].fe, got_q[$].brk);
      end
    end
  endtask

  task automatic test_glitch;
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 40);
    model_run(0, cyc); grab(0, cyc);
    n_tests++;
    if (got_q.size() !== 0 || exp_q.size() !== 0 || busy[0] !== 1'b0) begin
      n_fail++; $display("FAIL glitch_abort: got %0d events busy=%b, expected 0 events busy=0", got_q.size(), busy[0]);
    end
    send_frame(0, 8'h12, 2'b11, 30);
    model_run(0, cyc); grab(0, cyc);
    n_tests++;
    if (got_q.size() !== 1 || exp_q.size() !== 1) begin
      n_fail++; $display("FAIL glitch_next_count: got %0d events, expected 1", got_q.size());
    end else begin
      $display("[TB] glitch d0 cyc=%0d data=%h fe=%b brk=%b", got_q[0].cyc, got_q[0].data, got_q[0].fe, got_q[0].brk);
      n_tests++;
      if (got_q[0] !== exp_q[0] || got_q[0].data !== 8'h12) begin
        n_fail++; $display("FAIL glitch_next: got %h, expected %h (data 12)", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_enable;
    @(negedge clk); en[0] = 1'b0;
    send_frame(0, 8'h99, 2'b11, 20);
    @(negedge clk); en[0] = 1'b1;
    drive(0, 1'b1, 10);
    fork
      send_frame(0, 8'hC3, 2'b11, 30);
      begin
        repeat (40) @(negedge clk);
        en[0] = 1'b0;
      end
    join
    @(negedge clk); en[0] = 1'b1;
    model_run(0, cyc); grab(0, cyc);
    n_tests++;
    if (got_q.size() !== 1 || exp_q.size() !== 1) begin
      n_fail++; $display("FAIL enable_count: got %0d events, expected 1 (model %0d)", got_q.size(), exp_q.size());
    end else begin
      $display("[TB] enable d0 cyc=%0d data=%h fe=%b brk=%b", got_q[0].cyc, got_q[0].data, got_q[0].fe, got_q[0].brk);
      n_tests++;
      if (got_q[0] !== exp_q[0] || got_q[0].data !== 8'hC3) begin
        n_fail++; $display("FAIL enable_frame: got %h, expected %h (data c3)", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_stop2;
    send_frame(1, 8'h7E, 2'b01, 20);
    send_frame(1, 8'h3A, 2'b11, 30);
    model_run(1, cyc); grab(1, cyc);
    n_tests++;
    if (got_q.size() !== 2 || exp_q.size() !== 2) begin
      n_fail++; $display("FAIL stop2_count: got %0d events, expected 2 (model %0d)", got_q.size(), exp_q.size());
    end else begin
      foreach (got_q[i]) begin
        $display("[TB] stop2 d1 cyc=%0d data=%h fe=%b brk=%b", got_q[i].cyc, got_q[i].data, got_q[i].fe, got_q[i].brk);
        n_tests++;
        if (got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL stop2_model: got %h, expected %h", got_q[i], exp_q[i]);
        end
      end
      n_tests++;
      if ({got_q[0].data, got_q[0].fe, got_q[0].brk, got_q[1].data, got_q[1].fe} !== {8'h7E, 1'b1, 1'b0, 8'h3A, 1'b0}) begin
        n_fail++; $display("FAIL stop2_value: got %h fe=%b, %h fe=%b, expected 7e fe=1, 3a fe=0",
                           got_q[0].data, got_q[0].fe, got_q[1].data, got_q[1].fe);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic was_busy;
    was_busy = 1'b0;
    fork
      send_frame(1, 8'hB6, 2'b11, 20);
      begin
        @(negedge clk);
        repeat (52) @(negedge clk);
        was_busy = busy[1];
        resetn[1] = 1'b0;
        #1;
        n_tests++;
        if ({was_busy, busy[1], valid[1], data[1], fe[1], brk[1]} !== {1'b1, 12'h000}) begin
          n_fail++; $display("FAIL midreset_outputs: busy_before=%b busy=%b valid=%b data=%h fe=%b brk=%b, expected 1 then all 0",
                             was_busy, busy[1], valid[1], data[1], fe[1], brk[1]);
        end
      end
    join
    @(negedge clk);
    resetn[1] = 1'b1; rst_rel[1] = cyc + 1; model_n[1] = cyc + 1;
    drive(1, 1'b1, 10);
    send_frame(1, 8'h5A, 2'b11, 30);
    model_run(1, cyc); grab(1, cyc);
    n_tests++;
    if (got_q.size() !== 1 || exp_q.size() !== 1) begin
      n_fail++; $display("FAIL midreset_count: got %0d events, expected 1", got_q.size());
    end else begin
      $display("[TB] midreset d1 cyc=%0d data=%h fe=%b brk=%b", got_q[0].cyc, got_q[0].data, got_q[0].fe, got_q[0].brk);
      n_tests++;
      if (got_q[0] !== exp_q[0] || got_q[0].data !== 8'h5A) begin
        n_fail++; $display("FAIL midreset_next: got %h, expected %h (data 5a)", got_q[0], exp_q[0]);
      end
    end
  endtask

  task automatic test_random;
    logic [1:0] sv;
    for (int d = 0; d < 2; d++) begin
      for (int f = 0; f < 12; f++) begin
        sv = 2'b11;
        if ($urandom_range(0, 3) == 0) sv[$urandom_range(0, d)] = 1'b0;
        send_frame(d, 8'($urandom), sv, $urandom_range(0, 12));
      end
      drive(d, 1'b1, 40);
      model_run(d, cyc); grab(d, cyc);
      n_tests++;
      if (got_q.size() !== exp_q.size()) begin
        n_fail++; $display("FAIL random_count d%0d: got %0d events, expected %0d", d, got_q.size(), exp_q.size());
      end
      foreach (got_q[i]) begin
        $display("[TB] random d%0d cyc=%0d data=%h fe=%b brk=%b", d, got_q[i].cyc, got_q[i].data, got_q[i].fe, got_q[i].brk);
        n_tests++;
        if (i >= exp_q.size() || got_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL random_event d%0d #%0d: got %h, expected %h", d, i, got_q[i],
                             (i < exp_q.size()) ? exp_q[i] : '0);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_enable();
    test_stop2();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
